alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Shares the single combinational `ALU` instance of the execute stage between `NREQ` requesters, e.g. the main execute path and the branch/address-generation path. Each requester presents operands and an op code under valid/ready. A round-robin arbiter grants one requester per cycle and drives the ALU operand/choice inputs. The ALU output is captured in a one-entry response register tagged with the owner's index, which is held until that owner accepts it.

## Interface
Parameters:
- `BW`, 32, datapath width; must match the ALU's `BW`.
- `NREQ`, 2, number of requesters, 2..8.
- `IDW`, `$clog2(NREQ)`, width of the requester index (derived; not overridden).

Ports:
- `clock`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req_valid`  in  NREQ  per-requester request valid.
- `req_ready`  out  NREQ  per-requester grant/accept; one-hot or zero.
- `req_d1`  in  NREQ*BW  operand 1, requester i at bits [i*BW +: BW].
- `req_d2`  in  NREQ*BW  operand 2, same packing.
- `req_op`  in  NREQ*4  ALU choice code, requester i at bits [i*4 +: 4].
- `alu_d1`  out  BW  to ALU `d1`.
- `alu_d2`  out  BW  to ALU `d2`.
- `alu_choice`  out  4  to ALU `choice`.
- `alu_res`  in  BW  from ALU `res`.
- `rsp_valid`  out  NREQ  one-hot response valid for the owning requester.
- `rsp_ready`  in  NREQ  per-requester response accept.
- `rsp_res`  out  BW  registered result.
- `rsp_id`  out  IDW  owner index of the held result.

## Operation
- Slot free in cycle T when `rsp_valid==0`, or when `rsp_valid[rsp_id] && rsp_ready[rsp_id]` (drain and refill in the same cycle).
- If the slot is free and any `req_valid` is high, grant the first valid requester searching upward (wrapping) from `rr_ptr`. The grant is combinational in cycle T. `req_ready[g]=1`, all other `req_ready` bits are 0.
- If the slot is not free, all `req_ready` are 0. `req_ready` never depends on the requester's own `req_valid` beyond the grant selection.
- ALU mux:
  - When granted: `alu_d1/alu_d2/alu_choice` = the granted requester's fields.
  - Otherwise: operands 0 and `alu_choice = ALU_NOP`.
- On a grant at edge T: `rsp_res<=alu_res`, `rsp_id<=g`, `rsp_valid<=onehot(g)`, `rr_ptr<=(g+1)%NREQ`.
- On a drain without a new grant: `rsp_valid<=0`. `rsp_res` and `rsp_id` hold their values.
- `rr_ptr` changes only on a grant.
- Requester rules: once `req_valid` is asserted, its operands/op are held stable until `req_ready`. A requester drops `req_valid` only after acceptance.
- Responder rule: `rsp_ready` from a non-owner is ignored.
- Reset values (asynchronous): `rsp_valid=0`, `rsp_res=0`, `rsp_id=0`, `rr_ptr=0`. Outputs after reset: `req_ready=0` when no `req_valid` is high, and the ALU inputs are in the NOP state.
- Reset asserted mid-operation: any held result is discarded, and no response is issued after reset releases.

## Timing
- Request-to-response latency is 1 cycle: accepted at edge T, `rsp_valid` is high from T+1.
- Throughput is one operation per cycle when the owner asserts `rsp_ready` continuously.
- A held response stalls all requesters, including the owner, until it is drained. There is no second buffer entry.
- With all requesters valid continuously and responses drained every cycle, grant order is 0,1,...,NREQ-1,0,...
- Combinational path: `req_*` / `rsp_ready` -> grant -> mux -> ALU -> `rsp_res` D input, all within one cycle.

## Structure
- Shared package `alu_pkg`:
  - 4-bit op constants `ALU_ADD`, `ALU_SUB`, `ALU_AND`, `ALU_OR`, `ALU_XOR`, `ALU_SLT`, `ALU_SLTU`, `ALU_NE`, `ALU_SLL`, `ALU_SRL`, `ALU_SRA`, mirroring the existing `para.sv` encodings.
  - `ALU_NOP`: an encoding outside the defined set, for which the ALU yields 0.
  - `alu_op_t` typedef.
- Sub-module `rr_arbiter` (parameter `NREQ`): inputs `req`, `ptr`, `en`; outputs one-hot `gnt` and index `gnt_id`. Purely combinational.
- The ALU is instantiated outside this block; this block only drives and samples its ports.

## Test plan
- Reset mid-flight: with a valid response held, assert `reset` -> `rsp_valid`, `rsp_res`, `rsp_id` go to 0 immediately. After release, requester 0 wins first (`rr_ptr=0`).
- Single request: req0 with d1=5, d2=7, `ALU_ADD`, `rsp_ready=1` -> `req_ready[0]` in the same cycle; next cycle `rsp_valid=2'b01`, `rsp_res=12`, `rsp_id=0`.
- Contention, full throughput: both requesters valid for 4 cycles, req0 `ALU_SUB` 10-3, req1 `ALU_SLL` 1<<4, responses always ready -> grants 0,1,0,1; `rsp_res` sequence 7,16,7,16.
- Backpressure: req1 `ALU_SRA` 0x80000000>>4 granted, `rsp_ready[1]=0` for 3 cycles while req0 is valid -> `rsp_res=0xF8000000` held, `req_ready=0` throughout. In the cycle `rsp_ready[1]` rises, req0 is granted and the next response has id 0.
- Non-owner ready ignored: response owned by req0 and `rsp_ready=2'b10` -> response held, no new grant.
- Idle: no `req_valid` -> `alu_d1=0`, `alu_d2=0`, `alu_choice=ALU_NOP`, `rr_ptr` unchanged.

Source files
------------

// File: rtl/alu_pkg.sv
// Operation encodings shared by the execute-stage ALU and the blocks that drive it.
// ALU_NOP sits outside the defined set; the ALU returns 0 for it.
package alu_pkg;

  typedef logic [3:0] alu_op_t;

  localparam alu_op_t ALU_ADD  = 4'd0;
  localparam alu_op_t ALU_SUB  = 4'd1;
  localparam alu_op_t ALU_AND  = 4'd2;
  localparam alu_op_t ALU_OR   = 4'd3;
  localparam alu_op_t ALU_XOR  = 4'd4;
  localparam alu_op_t ALU_SLL  = 4'd5;
  localparam alu_op_t ALU_SRL  = 4'd6;
  localparam alu_op_t ALU_SRA  = 4'd7;
  localparam alu_op_t ALU_SLT  = 4'd8;
  localparam alu_op_t ALU_SLTU = 4'd9;
  localparam alu_op_t ALU_NE   = 4'd10;
  localparam alu_op_t ALU_NOP  = 4'd15;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first set request at or above ptr,
// wrapping, when en is high. Produces both a one-hot grant and its index.
module rr_arbiter #(
  parameter  int NREQ = 2,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  input  logic            en,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_id
);

  always_comb begin
    int   idx;
    logic found;
    // NOTE: every output gets a default before any branch so no latch is inferred.
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    idx    = 0;
    if (en) begin
      for (int k = 0; k < NREQ; k++) begin
        idx = (int'(ptr) + k) % NREQ;
        if (!found && req[idx]) begin
          found    = 1'b1;
          gnt[idx] = 1'b1;
          gnt_id   = IDW'(idx);
        end
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between NREQ requesters; the result lands in a
// single tagged response register that is held until its owner accepts it.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter  int BW   = 32,
  parameter  int NREQ = 2,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*BW-1:0] req_d1,
  input  logic [NREQ*BW-1:0] req_d2,
  input  logic [NREQ*4-1:0] req_op,
  output logic [BW-1:0]     alu_d1,
  output logic [BW-1:0]     alu_d2,
  output logic [3:0]        alu_choice,
  input  logic [BW-1:0]     alu_res,
  output logic [NREQ-1:0]   rsp_valid,
  input  logic [NREQ-1:0]   rsp_ready,
  output logic [BW-1:0]     rsp_res,
  output logic [IDW-1:0]    rsp_id
);

  logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [BW-1:0]   rsp_res_q,   rsp_res_d;
  logic [IDW-1:0]  rsp_id_q,    rsp_id_d;
  logic [IDW-1:0]  rr_ptr_q,    rr_ptr_d;

  logic            drain;
  logic            slot_free;
  logic            gnt_any;
  logic [NREQ-1:0] gnt;
  logic [IDW-1:0]  gnt_id;

  // rsp_valid_q is one-hot, so this only fires on the owner's ready.
  assign drain     = |(rsp_valid_q & rsp_ready);
  assign slot_free = (rsp_valid_q == '0) || drain;
  assign gnt_any   = |gnt;

  rr_arbiter #(.NREQ(NREQ)) u_rr_arbiter (
    .req    (req_valid),
    .ptr    (rr_ptr_q),
    .en     (slot_free),
    .gnt    (gnt),
    .gnt_id (gnt_id)
  );

  always_comb begin
    alu_d1     = '0;
    alu_d2     = '0;
    alu_choice = ALU_NOP;
    if (gnt_any) begin
      alu_d1     = req_d1[int'(gnt_id)*BW +: BW];
      alu_d2     = req_d2[int'(gnt_id)*BW +: BW];
      alu_choice = req_op[int'(gnt_id)*4 +: 4];
    end
  end

  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_res_d   = rsp_res_q;
    rsp_id_d    = rsp_id_q;
    rr_ptr_d    = rr_ptr_q;
    if (gnt_any) begin
      rsp_valid_d = gnt;
      rsp_res_d   = alu_res;
      rsp_id_d    = gnt_id;
      rr_ptr_d    = (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + IDW'(1);
    end else if (drain) begin
      rsp_valid_d = '0;
    end
  end

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rsp_valid_q <= '0;
      rsp_res_q   <= '0;
      rsp_id_q    <= '0;
      rr_ptr_q    <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_res_q   <= rsp_res_d;
      rsp_id_q    <= rsp_id_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign req_ready = gnt;
  assign rsp_valid = rsp_valid_q;
  assign rsp_res   = rsp_res_q;
  assign rsp_id    = rsp_id_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural ALU and a response scoreboard.
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int BW   = 32;
  localparam int NREQ = 2;
  localparam int IDW  = $clog2(NREQ);

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [BW-1:0]  res;
  } exp_t;

  logic               clock;
  logic               reset;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*BW-1:0] req_d1;
  logic [NREQ*BW-1:0] req_d2;
  logic [NREQ*4-1:0]  req_op;
  logic [BW-1:0]      alu_d1;
  logic [BW-1:0]      alu_d2;
  logic [3:0]         alu_choice;
  logic [BW-1:0]      alu_res;
  logic [NREQ-1:0]    rsp_valid;
  logic [NREQ-1:0]    rsp_ready;
  logic [BW-1:0]      rsp_res;
  logic [IDW-1:0]     rsp_id;

  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];

  alu_arbiter #(.BW(BW), .NREQ(NREQ)) dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_d1     (req_d1),
    .req_d2     (req_d2),
    .req_op     (req_op),
    .alu_d1     (alu_d1),
    .alu_d2     (alu_d2),
    .alu_choice (alu_choice),
    .alu_res    (alu_res),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_res    (rsp_res),
    .rsp_id     (rsp_id)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Stand-in for the execute-stage ALU that sits outside the arbiter.
  always_comb begin
    alu_res = '0;
    case (alu_choice)
      ALU_ADD:  alu_res = alu_d1 + alu_d2;
      ALU_SUB:  alu_res = alu_d1 - alu_d2;
      ALU_AND:  alu_res = alu_d1 & alu_d2;
      ALU_OR:   alu_res = alu_d1 | alu_d2;
      ALU_XOR:  alu_res = alu_d1 ^ alu_d2;
      ALU_SLL:  alu_res = alu_d1 << alu_d2[4:0];
      ALU_SRL:  alu_res = alu_d1 >> alu_d2[4:0];
      ALU_SRA:  alu_res = $signed(alu_d1) >>> alu_d2[4:0];
      ALU_SLT:  alu_res = BW'($signed(alu_d1) < $signed(alu_d2));
      ALU_SLTU: alu_res = BW'(alu_d1 < alu_d2);
      ALU_NE:   alu_res = BW'(alu_d1 != alu_d2);
      default:  alu_res = '0;
    endcase
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [BW-1:0] d1, input logic [BW-1:0] d2,
                         input alu_op_t op);
    req_d1[i*BW +: BW] = d1;
    req_d2[i*BW +: BW] = d2;
    req_op[i*4 +: 4]   = op;
  endtask

  task automatic push(input int id, input logic [BW-1:0] res);
    exp_t e;
    e.id  = IDW'(id);
    e.res = res;
    sb.push_back(e);
  endtask

  // Scoreboard pops on the falling edge whenever the owner takes the response.
  task automatic tick();
    exp_t e;
    @(negedge clock);
    if ((rsp_valid & rsp_ready) != '0) begin
      checks++;
      assert (sb.size() != 0)
      else begin
        errors++;
        $error("FAIL sb_unexpected_rsp: observed id=%0d res=%0h expected no response",
               rsp_id, rsp_res);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("sb_rsp_valid", 64'(rsp_valid), 64'(NREQ'(1) << e.id));
        check("sb_rsp_id", 64'(rsp_id), 64'(e.id));
        check("sb_rsp_res", 64'(rsp_res), 64'(e.res));
      end
    end
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = '0;
    req_d1    = '0;
    req_d2    = '0;
    req_op    = {NREQ{ALU_NOP}};
    rsp_ready = '0;

    @(posedge clock);
    #1;
    check("reset_rsp_valid", 64'(rsp_valid), 64'(0));
    check("reset_rsp_res", 64'(rsp_res), 64'(0));
    check("reset_req_ready", 64'(req_ready), 64'(0));
    check("reset_alu_choice", 64'(alu_choice), 64'(ALU_NOP));
    reset = 1'b0;
    tick();

    // Single request from requester 0.
    set_req(0, 32'd5, 32'd7, ALU_ADD);
    req_valid = 2'b01;
    rsp_ready = 2'b01;
    #1;
    check("single_req_ready", 64'(req_ready), 64'(2'b01));
    check("single_alu_d1", 64'(alu_d1), 64'(5));
    check("single_alu_d2", 64'(alu_d2), 64'(7));
    check("single_alu_choice", 64'(alu_choice), 64'(ALU_ADD));
    push(0, 32'd12);
    tick();
    req_valid = 2'b00;
    #1;
    check("single_rsp_valid", 64'(rsp_valid), 64'(2'b01));
    check("single_rsp_res", 64'(rsp_res), 64'(12));
    check("single_rsp_id", 64'(rsp_id), 64'(0));
    tick();
    check("single_drained", 64'(rsp_valid), 64'(0));

    // Held response from requester 1, then reset mid-flight.
    set_req(1, 32'h20, 32'h3, ALU_SUB);
    req_valid = 2'b10;
    rsp_ready = 2'b00;
    #1;
    check("rst_mid_req_ready", 64'(req_ready), 64'(2'b10));
    push(1, 32'h1D);
    tick();
    req_valid = 2'b00;
    #1;
    check("rst_mid_held_valid", 64'(rsp_valid), 64'(2'b10));
    check("rst_mid_held_id", 64'(rsp_id), 64'(1));
    reset = 1'b1;
    #1;
    check("rst_mid_rsp_valid", 64'(rsp_valid), 64'(0));
    check("rst_mid_rsp_res", 64'(rsp_res), 64'(0));
    check("rst_mid_rsp_id", 64'(rsp_id), 64'(0));
    sb.delete();
    tick();
    reset = 1'b0;
    #1;
    check("rst_rel_rsp_valid", 64'(rsp_valid), 64'(0));
    tick();
    check("rst_rel_no_rsp", 64'(rsp_valid), 64'(0));

    // Contention at full throughput: grant order 0,1,0,1.
    set_req(0, 32'd10, 32'd3, ALU_SUB);
    set_req(1, 32'd1, 32'd4, ALU_SLL);
    req_valid = 2'b11;
    rsp_ready = 2'b11;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("contend_req_ready", 64'(req_ready), 64'(2'b01 << (i % 2)));
      push(i % 2, (i % 2 == 1) ? 32'd16 : 32'd7);
      tick();
    end
    req_valid = 2'b00;
    tick();

    // Backpressure: requester 1 result held, requester 0 stalled.
    set_req(1, 32'h8000_0000, 32'd4, ALU_SRA);
    req_valid = 2'b10;
    rsp_ready = 2'b00;
    #1;
    check("bp_req_ready_1", 64'(req_ready), 64'(2'b10));
    push(1, 32'hF800_0000);
    tick();
    set_req(0, 32'd5, 32'd7, ALU_ADD);
    req_valid = 2'b01;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_stall_req_ready", 64'(req_ready), 64'(0));
      check("bp_held_valid", 64'(rsp_valid), 64'(2'b10));
      check("bp_held_res", 64'(rsp_res), 64'(32'hF800_0000));
      check("bp_stall_alu_nop", 64'(alu_choice), 64'(ALU_NOP));
      tick();
    end
    rsp_ready = 2'b10;
    #1;
    check("bp_refill_req_ready", 64'(req_ready), 64'(2'b01));
    push(0, 32'd12);
    tick();
    req_valid = 2'b00;
    rsp_ready = 2'b01;
    #1;
    check("bp_next_id", 64'(rsp_id), 64'(0));
    check("bp_next_valid", 64'(rsp_valid), 64'(2'b01));
    tick();

    // Idle: ALU inputs parked, pointer (now 1) must not move.
    rsp_ready = 2'b00;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("idle_alu_d1", 64'(alu_d1), 64'(0));
      check("idle_alu_d2", 64'(alu_d2), 64'(0));
      check("idle_alu_choice", 64'(alu_choice), 64'(ALU_NOP));
      check("idle_req_ready", 64'(req_ready), 64'(0));
      tick();
    end
    set_req(0, 32'hF0, 32'hFF, ALU_XOR);
    set_req(1, 32'd3, 32'd4, ALU_OR);
    req_valid = 2'b11;
    #1;
    check("idle_ptr_kept", 64'(req_ready), 64'(2'b10));
    push(1, 32'd7);
    tick();

    // Non-owner ready is ignored while requester 1 owns the slot.
    req_valid = 2'b01;
    rsp_ready = 2'b01;
    for (int i = 0; i < 2; i++) begin
      #1;
      check("nonowner_req_ready", 64'(req_ready), 64'(0));
      check("nonowner_rsp_valid", 64'(rsp_valid), 64'(2'b10));
      check("nonowner_rsp_id", 64'(rsp_id), 64'(1));
      check("nonowner_rsp_res", 64'(rsp_res), 64'(7));
      tick();
    end
    rsp_ready = 2'b10;
    #1;
    check("owner_drain_grant", 64'(req_ready), 64'(2'b01));
    push(0, 32'h0F);
    tick();
    req_valid = 2'b00;
    rsp_ready = 2'b01;
    tick();
    check("final_drained", 64'(rsp_valid), 64'(0));
    check("sb_empty", 64'(sb.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
